// File: rtl/wb_decoder_scoreboard_if.sv
// Bus bundle between issue/writeback stages and the writeback decoder/scoreboard.
interface wb_decoder_scoreboard_if #(
   parameter int unsigned ADDR_WIDTH = 5
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic                  issue_ready;
   logic                  wb_valid;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [NUM_REGS-1:0]   wb_enable;
   logic                  wb_error;
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic                  rs1_hazard;
   logic                  rs2_hazard;
   logic [NUM_REGS-1:0]   pending;
   logic [ADDR_WIDTH:0]   busy_count;

   // Pipeline side: drives requests and addresses, observes status.
   modport master (
      output issue_valid, issue_addr, wb_valid, wb_addr, rs1_addr, rs2_addr,
      input  issue_ready, wb_enable, wb_error, rs1_hazard, rs2_hazard, pending, busy_count
   );

   // Scoreboard side.
   modport slave (
      input  issue_valid, issue_addr, wb_valid, wb_addr, rs1_addr, rs2_addr,
      output issue_ready, wb_enable, wb_error, rs1_hazard, rs2_hazard, pending, busy_count
   );
endinterface

// File: rtl/wb_decoder_scoreboard.sv
// Writeback-select decoder with a register-pending scoreboard: one-hot
// register-file write enables, WAW issue stall and RAW hazard flags.
module wb_decoder_scoreboard #(
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter bit          ZERO_REG_RO = 1'b1
) (
   input logic                     clock,
   input logic                     reset,
   wb_decoder_scoreboard_if.slave  bus
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W    = ADDR_WIDTH + 1;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [NUM_REGS-1:0] wb_enable_q, wb_enable_d;
   logic                wb_error_q, wb_error_d;
   logic [CNT_W-1:0]    busy_q, busy_d;

   logic issue_zero, wb_zero, rs1_zero, rs2_zero;
   logic issue_fire, wb_hit;

   // Register 0 is treated as a constant when it is hard-wired.
   assign issue_zero = ZERO_REG_RO && (bus.issue_addr == '0);
   assign wb_zero    = ZERO_REG_RO && (bus.wb_addr == '0);
   assign rs1_zero   = ZERO_REG_RO && (bus.rs1_addr == '0);
   assign rs2_zero   = ZERO_REG_RO && (bus.rs2_addr == '0);

   // Stall only on registered state so there is no wb -> issue_ready path.
   assign bus.issue_ready = issue_zero | ~pending_q[bus.issue_addr];
   assign issue_fire      = bus.issue_valid & bus.issue_ready & ~issue_zero;
   assign wb_hit          = bus.wb_valid & pending_q[bus.wb_addr];

   // Source stays hazarded through the cycle its write enable is asserted.
   assign bus.rs1_hazard = ~rs1_zero & (pending_q[bus.rs1_addr] | wb_enable_q[bus.rs1_addr]);
   assign bus.rs2_hazard = ~rs2_zero & (pending_q[bus.rs2_addr] | wb_enable_q[bus.rs2_addr]);

   // Next scoreboard state, decoded enable, error pulse and occupancy.
   always_comb begin
      pending_d   = pending_q;
      wb_enable_d = '0;
      wb_error_d  = 1'b0;
      busy_d      = '0;

      if (wb_hit) begin
         pending_d[bus.wb_addr] = 1'b0;
         wb_enable_d            = NUM_REGS'(1) << bus.wb_addr;
      end else if (bus.wb_valid && !wb_zero) begin
         wb_error_d = 1'b1;
      end

      // Same-address collision cannot happen: issue_ready is low while pending.
      if (issue_fire) begin
         pending_d[bus.issue_addr] = 1'b1;
      end

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         busy_d = busy_d + CNT_W'(pending_d[i]);
      end
   end

   // State registers with synchronous reset that discards in-flight writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q   <= '0;
         wb_enable_q <= '0;
         wb_error_q  <= 1'b0;
         busy_q      <= '0;
      end else begin
         pending_q   <= pending_d;
         wb_enable_q <= wb_enable_d;
         wb_error_q  <= wb_error_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.pending    = pending_q;
   assign bus.wb_enable  = wb_enable_q;
   assign bus.wb_error   = wb_error_q;
   assign bus.busy_count = busy_q;
endmodule

// File: tb/tb_wb_decoder_scoreboard.sv
// Directed bench for wb_decoder_scoreboard: default build plus a 3-bit,
// non-hard-wired-zero build.
module tb_wb_decoder_scoreboard;
   localparam int unsigned AW  = 5;
   localparam int unsigned AW3 = 3;

   logic clock = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   wb_decoder_scoreboard_if #(.ADDR_WIDTH(AW))  bus  ();
   wb_decoder_scoreboard_if #(.ADDR_WIDTH(AW3)) bus3 ();

   wb_decoder_scoreboard #(.ADDR_WIDTH(AW), .ZERO_REG_RO(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   wb_decoder_scoreboard #(.ADDR_WIDTH(AW3), .ZERO_REG_RO(1'b0)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3.slave)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid  = 1'b0;
      bus.issue_addr   = '0;
      bus.wb_valid     = 1'b0;
      bus.wb_addr      = '0;
      bus.rs1_addr     = '0;
      bus.rs2_addr     = '0;
      bus3.issue_valid = 1'b0;
      bus3.issue_addr  = '0;
      bus3.wb_valid    = 1'b0;
      bus3.wb_addr     = '0;
      bus3.rs1_addr    = '0;
      bus3.rs2_addr    = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL reset_pending got %h exp %h", bus.pending, 32'h0); end
      tests++; if (bus.busy_count !== 6'd0) begin fails++; $display("FAIL reset_busy got %0d exp 0", bus.busy_count); end
      tests++; if (bus.wb_enable !== 32'h0) begin fails++; $display("FAIL reset_wb_enable got %h exp 0", bus.wb_enable); end
      tests++; if (bus.wb_error !== 1'b0) begin fails++; $display("FAIL reset_wb_error got %b exp 0", bus.wb_error); end
      // Load three destinations, then reset with a colliding writeback.
      bus.issue_valid = 1'b1;
      bus.issue_addr = 5'd3;  tick();
      bus.issue_addr = 5'd7;  tick();
      bus.issue_addr = 5'd12; tick();
      bus.issue_valid = 1'b0;
      tests++; if (bus.pending !== 32'h0000_1088) begin fails++; $display("FAIL preload_pending got %h exp %h", bus.pending, 32'h0000_1088); end
      tests++; if (bus.busy_count !== 6'd3) begin fails++; $display("FAIL preload_busy got %0d exp 3", bus.busy_count); end
      reset = 1'b1;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd3;
      tick();
      reset = 1'b0;
      idle();
      tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL midreset_pending got %h exp 0", bus.pending); end
      tests++; if (bus.busy_count !== 6'd0) begin fails++; $display("FAIL midreset_busy got %0d exp 0", bus.busy_count); end
      tests++; if (bus.wb_enable !== 32'h0) begin fails++; $display("FAIL midreset_wb_enable got %h exp 0", bus.wb_enable); end
      tests++; if (bus.wb_error !== 1'b0) begin fails++; $display("FAIL midreset_wb_error got %b exp 0", bus.wb_error); end
   endtask

   task automatic test_basic();
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd5;
      tick();
      bus.issue_valid = 1'b0;
      tests++; if (bus.pending !== 32'h0000_0020) begin fails++; $display("FAIL basic_pending got %h exp %h", bus.pending, 32'h20); end
      tests++; if (bus.busy_count !== 6'd1) begin fails++; $display("FAIL basic_busy got %0d exp 1", bus.busy_count); end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd5;
      tick();
      bus.wb_valid = 1'b0;
      tests++; if (bus.wb_enable !== 32'h0000_0020) begin fails++; $display("FAIL basic_wb_enable got %h exp %h", bus.wb_enable, 32'h20); end
      tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL basic_cleared got %h exp 0", bus.pending); end
      tests++; if (bus.busy_count !== 6'd0) begin fails++; $display("FAIL basic_busy0 got %0d exp 0", bus.busy_count); end
      tests++; if (bus.wb_error !== 1'b0) begin fails++; $display("FAIL basic_no_error got %b exp 0", bus.wb_error); end
      tick();
      tests++; if (bus.wb_enable !== 32'h0) begin fails++; $display("FAIL basic_enable_pulse got %h exp 0", bus.wb_enable); end
   endtask

   task automatic test_waw();
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd9;
      tick();
      // Same-address issue and writeback in one cycle.
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd9;
      #1;
      tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL waw_stall got %b exp 0", bus.issue_ready); end
      tick();
      bus.wb_valid = 1'b0;
      #1;
      tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL waw_release got %b exp 1", bus.issue_ready); end
      tests++; if (bus.wb_enable !== 32'h0000_0200) begin fails++; $display("FAIL waw_wb_enable got %h exp %h", bus.wb_enable, 32'h200); end
      tick();
      bus.issue_valid = 1'b0;
      tests++; if (bus.pending !== 32'h0000_0200) begin fails++; $display("FAIL waw_reissue got %h exp %h", bus.pending, 32'h200); end
      tests++; if (bus.busy_count !== 6'd1) begin fails++; $display("FAIL waw_busy got %0d exp 1", bus.busy_count); end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd9;
      tick();
      bus.wb_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd4;
      tick();
      // Different addresses in the same cycle both take effect.
      bus.issue_addr = 5'd6;
      bus.wb_valid   = 1'b1;
      bus.wb_addr    = 5'd4;
      tick();
      idle();
      tests++; if (bus.pending !== 32'h0000_0040) begin fails++; $display("FAIL b2b_pending got %h exp %h", bus.pending, 32'h40); end
      tests++; if (bus.wb_enable !== 32'h0000_0010) begin fails++; $display("FAIL b2b_wb_enable got %h exp %h", bus.wb_enable, 32'h10); end
      tests++; if (bus.busy_count !== 6'd1) begin fails++; $display("FAIL b2b_busy got %0d exp 1", bus.busy_count); end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd6;
      tick();
      bus.wb_valid = 1'b0;
      tick();
   endtask

   task automatic test_raw();
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd17;
      bus.rs1_addr    = 5'd17;
      bus.rs2_addr    = 5'd18;
      tick();
      bus.issue_valid = 1'b0;
      #1;
      tests++; if (bus.rs1_hazard !== 1'b1) begin fails++; $display("FAIL raw_pending got %b exp 1", bus.rs1_hazard); end
      tests++; if (bus.rs2_hazard !== 1'b0) begin fails++; $display("FAIL raw_other got %b exp 0", bus.rs2_hazard); end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd17;
      tick();
      bus.wb_valid = 1'b0;
      #1;
      tests++; if (bus.wb_enable !== 32'h0002_0000) begin fails++; $display("FAIL raw_wb_enable got %h exp %h", bus.wb_enable, 32'h0002_0000); end
      tests++; if (bus.rs1_hazard !== 1'b1) begin fails++; $display("FAIL raw_enable_cycle got %b exp 1", bus.rs1_hazard); end
      bus.rs2_addr = 5'd17;
      #1;
      tests++; if (bus.rs2_hazard !== 1'b1) begin fails++; $display("FAIL raw_rs2_enable_cycle got %b exp 1", bus.rs2_hazard); end
      tick();
      tests++; if (bus.rs1_hazard !== 1'b0) begin fails++; $display("FAIL raw_cleared got %b exp 0", bus.rs1_hazard); end
      idle();
   endtask

   task automatic test_zero_and_error();
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd0;
      #1;
      tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL zero_ready got %b exp 1", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0;
      tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL zero_pending got %h exp 0", bus.pending); end
      #1;
      tests++; if (bus.rs1_hazard !== 1'b0) begin fails++; $display("FAIL zero_hazard got %b exp 0", bus.rs1_hazard); end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd0;
      tick();
      tests++; if (bus.wb_enable !== 32'h0) begin fails++; $display("FAIL zero_wb_enable got %h exp 0", bus.wb_enable); end
      tests++; if (bus.wb_error !== 1'b0) begin fails++; $display("FAIL zero_wb_error got %b exp 0", bus.wb_error); end
      bus.wb_addr = 5'd22;
      tick();
      bus.wb_valid = 1'b0;
      tests++; if (bus.wb_enable !== 32'h0) begin fails++; $display("FAIL err_wb_enable got %h exp 0", bus.wb_enable); end
      tests++; if (bus.wb_error !== 1'b1) begin fails++; $display("FAIL err_pulse got %b exp 1", bus.wb_error); end
      tick();
      tests++; if (bus.wb_error !== 1'b0) begin fails++; $display("FAIL err_one_cycle got %b exp 0", bus.wb_error); end
   endtask

   task automatic test_param();
      logic [7:0] onehot [8];
      onehot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      bus3.issue_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus3.issue_addr = 3'(i);
         tick();
      end
      bus3.issue_valid = 1'b0;
      tests++; if (bus3.pending !== 8'hFF) begin fails++; $display("FAIL p3_pending got %h exp ff", bus3.pending); end
      tests++; if (bus3.busy_count !== 4'd8) begin fails++; $display("FAIL p3_busy_full got %0d exp 8", bus3.busy_count); end
      bus3.wb_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus3.wb_addr = 3'(i);
         tick();
         tests++; if (bus3.wb_enable !== onehot[i]) begin fails++; $display("FAIL p3_enable[%0d] got %h exp %h", i, bus3.wb_enable, onehot[i]); end
         tests++; if (bus3.busy_count !== 4'(7 - i)) begin fails++; $display("FAIL p3_busy[%0d] got %0d exp %0d", i, bus3.busy_count, 7 - i); end
      end
      bus3.wb_valid = 1'b0;
      tick();
      tests++; if (bus3.wb_enable !== 8'h00) begin fails++; $display("FAIL p3_idle_enable got %h exp 0", bus3.wb_enable); end
      tests++; if (bus3.pending !== 8'h00) begin fails++; $display("FAIL p3_empty got %h exp 0", bus3.pending); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_waw();
      test_back_to_back();
      test_raw();
      test_zero_and_error();
      test_param();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
